rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
- Round-robin arbiter with a grant-hold state machine. Sits directly upstream of the 4-to-2 encoder (encoder_4X2).
- Takes four request lines and drives a strictly one-hot (or all-zero) 4-bit grant vector. The grant vector feeds the encoder's I input, which turns it into a 2-bit requester ID.
- Bounds how long any requester holds the grant, and rotates priority so that no requester starves.

Parameters:
- MAX_HOLD, 8, maximum cycles a grant may be held before forced release. Legal range 1..255. Hold counter is 8 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request lines. req[i] high = requester i wants the resource. Level-sensitive.
- release  input  1  owner finished. Sampled only in GRANT.
- gnt  output  4  one-hot grant to the encoder I input. 4'b0000 when no grant.
- gnt_valid  output  1  high exactly when gnt is non-zero. Disambiguates the encoder's 2'b00 output.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Single clock domain clk. rst is asynchronous and active-high.
- rst asserted → immediately, without waiting for clk: gnt=4'b0000, gnt_valid=0, timeout=0, state=IDLE, ptr=0, hold_cnt=0. This applies mid-grant too.
- All outputs are registered. No combinational path from req or release to any output.
- State IDLE:
  - req==0 → remain in IDLE, gnt=0.
  - req!=0 → on the next edge, grant the first asserted req[k], searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - In the same edge: gnt=one-hot(k), gnt_valid=1, idx=k, hold_cnt=0, state→GRANT.
  - Latency: req sampled high at edge n → gnt visible after edge n.
- State GRANT: gnt held constant and hold_cnt increments each cycle. Exit conditions, evaluated at each edge in priority order:
  1. release==1 → normal exit, timeout=0.
  2. req[idx]==0 → requester withdrew; treated as a normal exit, timeout=0.
  3. hold_cnt==MAX_HOLD-1 → forced exit; timeout=1 for exactly one cycle.
- On any exit:
  - gnt=0, gnt_valid=0, state→IDLE, ptr=(idx+1) mod 4 with 2-bit wrap (3→0).
  - The arbiter spends at least one cycle in IDLE with gnt=0 between consecutive grants, including back-to-back requests.
- Simultaneous release and timeout condition: release wins and no timeout pulse is generated.
- With MAX_HOLD=1, every grant lasts exactly one cycle unless released. timeout pulses on the edge that ends the grant.
- While in GRANT, changes in req of non-owners are ignored until the next IDLE evaluation.
- ptr updates only on grant exit. It is never modified in IDLE.
- Invariant: gnt is always 4'b0000 or exactly one bit set, and gnt_valid==|gnt.

Test Plan:
- Reset/idle: assert rst mid-cycle with req=4'b1111 → gnt=0, gnt_valid=0 immediately. After release of rst with req=0, gnt stays 0 indefinitely.
- Basic grant and release:
  - req=4'b0100 from reset → gnt=4'b0100 one edge later, and encoder out=2'b10.
  - Pulse release → next edge gnt=0. Following edge, gnt=4'b0100 again, since ptr=3 and search order is 3,0,1,2.
- Round-robin rotation:
  - req=4'b1111 held, release pulsed in every GRANT cycle.
  - Grant sequence is 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001 (wrap).
- Timeout:
  - MAX_HOLD=8, req=4'b0001 held, release=0.
  - gnt=0001 for exactly 8 cycles. timeout pulses once, on the edge gnt drops. Then gnt=0 for one cycle and 0001 is re-granted.
- Simultaneous release and timeout: release asserted on the 8th grant cycle → gnt drops and timeout stays 0.
- Requester withdrawal and reset mid-grant:
  - Owner 2 drops req[2] in cycle 3 of its grant → gnt=0 next edge, ptr=3, timeout=0.
  - Separately, assert rst during any grant → gnt=0 asynchronously. Next grant after reset starts the search from index 0.

Source files
------------

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The owner-finished strobe is named rel because "release" is a reserved word.
interface rr_arbiter_4_if;
  logic [3:0] req;        // level-sensitive requests, bit i = requester i
  logic       rel;        // owner finished, only looked at while granted
  logic [3:0] gnt;        // one-hot grant (feeds encoder I input), 0 when idle
  logic       gnt_valid;  // high exactly when gnt != 0
  logic       timeout;    // one-cycle pulse on a forced release

  modport master (
    input  req, rel,
    output gnt, gnt_valid, timeout
  );

  modport slave (
    output req, rel,
    input  gnt, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with bounded grant hold.
// Every grant is followed by at least one idle cycle with gnt=0. The search
// pointer moves past the previous owner only when a grant ends, so no
// requester can starve. All outputs are registered.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8  // legal 1..255, grant cycles before forced release
) (
  input  logic            clk,
  input  logic            rst,
  rr_arbiter_4_if.master  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] LAST_CNT = 8'(MAX_HOLD - 1);

  state_t     state;
  logic [1:0] ptr;       // first index searched on the next IDLE evaluation
  logic [1:0] idx;       // current owner
  logic [7:0] hold_cnt;  // grant cycles already spent, minus one

  // Rotated view of the requests: position i holds requester (ptr + i) mod 4.
  logic [3:0][1:0] cand;
  logic [3:0]      rot_req;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign cand[gi]    = ptr + 2'(gi);
      assign rot_req[gi] = bus.req[cand[gi]];
    end
  endgenerate

  logic       found;
  logic [1:0] pick;

  // Lowest rotated position wins: scan downward so the last hit is the nearest to ptr.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot_req[i]) begin
        found = 1'b1;
        pick  = cand[i];
      end
    end
  end

  logic owner_drop;
  logic hold_done;
  assign owner_drop = ~bus.req[idx];
  assign hold_done  = (hold_cnt == LAST_CNT);

  // Grant/hold state machine; release beats withdrawal, and both beat timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= 2'd0;
      idx           <= 2'd0;
      hold_cnt      <= 8'd0;
      bus.gnt       <= 4'b0000;
      bus.gnt_valid <= 1'b0;
      bus.timeout   <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            bus.gnt       <= 4'b0001 << pick;
            bus.gnt_valid <= 1'b1;
            idx           <= pick;
            hold_cnt      <= 8'd0;
            state         <= GRANT;
          end
        end
        GRANT: begin
          if (bus.rel || owner_drop || hold_done) begin
            bus.gnt       <= 4'b0000;
            bus.gnt_valid <= 1'b0;
            bus.timeout   <= ~bus.rel & ~owner_drop;
            ptr           <= idx + 2'd1;
            state         <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: expected outputs are queued when a step
// is driven and popped for comparison once the clock edge has been taken.
module tb_rr_arbiter_4;

  logic clk;
  logic rst;

  rr_arbiter_4_if bus ();

  rr_arbiter_4 #(.MAX_HOLD(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic       to;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Pop one expectation and compare it against the live outputs.
  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got 0 entries want 1");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (bus.gnt === e.gnt) else begin
      errors++;
      $error("FAIL %s gnt got %b want %b", e.tag, bus.gnt, e.gnt);
    end
    checks++;
    assert (bus.gnt_valid === (|e.gnt)) else begin
      errors++;
      $error("FAIL %s gnt_valid got %b want %b", e.tag, bus.gnt_valid, |e.gnt);
    end
    checks++;
    assert (bus.timeout === e.to) else begin
      errors++;
      $error("FAIL %s timeout got %b want %b", e.tag, bus.timeout, e.to);
    end
  endtask

  // Drive inputs on the falling edge, check just after the next rising edge.
  task automatic step(input logic [3:0] r, input logic rl,
                      input logic [3:0] eg, input logic et, input string tag);
    exp_t e;
    @(negedge clk);
    bus.req = r;
    bus.rel = rl;
    e.gnt = eg; e.to = et; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare();
  endtask

  // Check outputs right now, without waiting for a clock edge.
  task automatic check_now(input logic [3:0] eg, input logic et, input string tag);
    exp_t e;
    e.gnt = eg; e.to = et; e.tag = tag;
    sb.push_back(e);
    compare();
  endtask

  initial begin
    clk     = 1'b0;
    rst     = 1'b1;
    bus.req = 4'b1111;
    bus.rel = 1'b0;

    // Reset held with all requests asserted: nothing granted.
    @(posedge clk); @(posedge clk); #1;
    check_now(4'b0000, 1'b0, "reset_hold");
    @(negedge clk);
    rst     = 1'b0;
    bus.req = 4'b0000;

    // Idle with no requests stays idle.
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 4'b0000, 1'b0, "idle");

    // Basic grant, release, re-grant from ptr=3 (search 3,0,1,2).
    step(4'b0100, 1'b0, 4'b0100, 1'b0, "basic_grant");
    step(4'b0100, 1'b1, 4'b0000, 1'b0, "basic_release");
    step(4'b0100, 1'b0, 4'b0100, 1'b0, "basic_regrant");
    step(4'b0000, 1'b1, 4'b0000, 1'b0, "basic_end");

    // Reset pulse in IDLE returns ptr to 0.
    #1 rst = 1'b1;
    #1 check_now(4'b0000, 1'b0, "reset_idle");
    @(negedge clk) rst = 1'b0;

    // Round-robin rotation with release pulsed in every grant cycle.
    step(4'b1111, 1'b0, 4'b0001, 1'b0, "rr_g0");
    step(4'b1111, 1'b1, 4'b0000, 1'b0, "rr_i0");
    step(4'b1111, 1'b0, 4'b0010, 1'b0, "rr_g1");
    step(4'b1111, 1'b1, 4'b0000, 1'b0, "rr_i1");
    step(4'b1111, 1'b0, 4'b0100, 1'b0, "rr_g2");
    step(4'b1111, 1'b1, 4'b0000, 1'b0, "rr_i2");
    step(4'b1111, 1'b0, 4'b1000, 1'b0, "rr_g3");
    step(4'b1111, 1'b1, 4'b0000, 1'b0, "rr_i3");
    step(4'b1111, 1'b0, 4'b0001, 1'b0, "rr_wrap");
    step(4'b0000, 1'b1, 4'b0000, 1'b0, "rr_end");   // ptr -> 1

    // Timeout: 8 grant cycles, pulse on the drop edge, one idle, re-grant.
    step(4'b0001, 1'b0, 4'b0001, 1'b0, "to_grant");
    for (int i = 0; i < 7; i++) step(4'b0001, 1'b0, 4'b0001, 1'b0, "to_hold");
    step(4'b0001, 1'b0, 4'b0000, 1'b1, "to_pulse");
    step(4'b0001, 1'b0, 4'b0001, 1'b0, "to_regrant");

    // Release on the 8th grant cycle beats the timeout.
    for (int i = 0; i < 7; i++) step(4'b0001, 1'b0, 4'b0001, 1'b0, "sim_hold");
    step(4'b0001, 1'b1, 4'b0000, 1'b0, "sim_release");  // ptr -> 1

    // Owner 2 withdraws in cycle 3 of its grant; ptr becomes 3.
    step(4'b0100, 1'b0, 4'b0100, 1'b0, "wd_grant");
    step(4'b0100, 1'b0, 4'b0100, 1'b0, "wd_c2");
    step(4'b0110, 1'b0, 4'b0100, 1'b0, "wd_nonowner");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "wd_drop");
    step(4'b1111, 1'b0, 4'b1000, 1'b0, "wd_ptr3");
    step(4'b1111, 1'b0, 4'b1000, 1'b0, "wd_hold");

    // Asynchronous reset mid-grant; next search starts from 0.
    #1 rst = 1'b1;
    #1 check_now(4'b0000, 1'b0, "rst_midgrant");
    @(posedge clk); #1;
    check_now(4'b0000, 1'b0, "rst_held");
    @(negedge clk) rst = 1'b0;
    step(4'b1111, 1'b0, 4'b0001, 1'b0, "post_rst_grant");
    step(4'b1111, 1'b0, 4'b0001, 1'b0, "post_rst_hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
